// File: rtl/servo_pkg.sv
// Shared timing constants and state encoding for the servo PWM link.
// The PWM generator and pwm_capture both consume these defaults so the two ends agree.
package servo_pkg;

  localparam int unsigned CLK_FREQ = 100_000_000;

  localparam int unsigned DEFAULT_OFFSET_CYCLES   = 100_000;    // 1.0 ms decodes to 0
  localparam int unsigned DEFAULT_TICK_CYCLES     = 390;        // cycles per command LSB
  localparam int unsigned DEFAULT_MAX_HIGH_CYCLES = 250_000;    // 2.5 ms rejected as too long
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 2_500_000;  // 25 ms without a rising edge

  localparam int HIGH_CNT_W    = 18;
  localparam int SUB_CNT_W     = 9;
  localparam int TICK_CNT_W    = 8;
  localparam int TIMEOUT_CNT_W = 22;

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    OFFSET,
    MEASURE
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM pin into the clk domain and detects its edges.
// Rise and fall share the same pipeline delay, so measured widths are unbiased.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // NOTE: non-blocking assignments make s1->s2->s3 a true shift register; blocking ones would collapse it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures the high time of a servo PWM pulse and decodes it to an 8-bit command,
// flagging out-of-range pulses and loss of signal.
module pwm_capture
  import servo_pkg::*;
#(
  parameter int unsigned OFFSET_CYCLES   = DEFAULT_OFFSET_CYCLES,
  parameter int unsigned TICK_CYCLES     = DEFAULT_TICK_CYCLES,
  parameter int unsigned MAX_HIGH_CYCLES = DEFAULT_MAX_HIGH_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] value,
  output logic       valid,
  output logic       range_err,
  output logic       signal_lost
);

  if (OFFSET_CYCLES < 2 || MAX_HIGH_CYCLES <= OFFSET_CYCLES ||
      MAX_HIGH_CYCLES >= (1 << HIGH_CNT_W) || TICK_CYCLES < 1 ||
      TICK_CYCLES > (1 << SUB_CNT_W) || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES >= (1 << TIMEOUT_CNT_W)) begin : g_bad_params
    $error("pwm_capture: timing parameters do not fit the counter widths");
  end

  localparam logic [HIGH_CNT_W-1:0]    OFFSET_LAST  = HIGH_CNT_W'(OFFSET_CYCLES - 1);
  localparam logic [HIGH_CNT_W-1:0]    MAX_LAST     = HIGH_CNT_W'(MAX_HIGH_CYCLES - 1);
  localparam logic [SUB_CNT_W-1:0]     SUB_LAST     = SUB_CNT_W'(TICK_CYCLES - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_SAT  = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

  logic level, rise, fall;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  cap_state_e                state;
  logic [HIGH_CNT_W-1:0]     high_cnt;
  logic [SUB_CNT_W-1:0]      sub_cnt;
  logic [TICK_CNT_W-1:0]     tick_cnt;
  logic [TIMEOUT_CNT_W-1:0]  timeout_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= WAIT_LOW;
      high_cnt    <= '0;
      sub_cnt     <= '0;
      tick_cnt    <= '0;
      timeout_cnt <= '0;
      value       <= '0;
      valid       <= 1'b0;
      range_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      valid     <= 1'b0;
      range_err <= 1'b0;

      if (rise)
        timeout_cnt <= '0;
      else if (timeout_cnt != TIMEOUT_SAT)
        timeout_cnt <= timeout_cnt + TIMEOUT_CNT_W'(1);

      unique case (state)
        WAIT_LOW: begin
          // high_cnt first counts two cycles so reset values in the synchronizer are flushed
          // before a low level is trusted; otherwise a pulse present at reset looks fresh.
          if (high_cnt < HIGH_CNT_W'(2))
            high_cnt <= high_cnt + HIGH_CNT_W'(1);
          else if (!level)
            state <= IDLE;
        end

        IDLE: begin
          if (rise) begin
            high_cnt <= HIGH_CNT_W'(1);
            sub_cnt  <= '0;
            tick_cnt <= '0;
            state    <= OFFSET;
          end
        end

        OFFSET: begin
          if (fall) begin
            value     <= '0;
            valid     <= 1'b1;
            range_err <= 1'b1;
            state     <= IDLE;
          end else begin
            high_cnt <= high_cnt + HIGH_CNT_W'(1);
            if (high_cnt == OFFSET_LAST)
              state <= MEASURE;
          end
        end

        MEASURE: begin
          if (fall) begin
            value       <= tick_cnt;
            valid       <= 1'b1;
            signal_lost <= 1'b0;
            state       <= IDLE;
          end else if (high_cnt == MAX_LAST) begin
            range_err <= 1'b1;
            state     <= WAIT_LOW;
          end else begin
            high_cnt <= high_cnt + HIGH_CNT_W'(1);
            if (sub_cnt == SUB_LAST) begin
              sub_cnt <= '0;
              if (tick_cnt != '1)
                tick_cnt <= tick_cnt + TICK_CNT_W'(1);
            end else begin
              sub_cnt <= sub_cnt + SUB_CNT_W'(1);
            end
          end
        end

        default: state <= WAIT_LOW;
      endcase

      // Placed last so a timeout wins even when a rise clears the counter in the same cycle.
      if (timeout_cnt == TIMEOUT_LAST)
        signal_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture with scaled-down timing: pulses are predicted from their widths
// and every output is compared against that prediction on every clock.
module tb_pwm_capture;

  localparam int unsigned O  = 100;
  localparam int unsigned T  = 3;
  localparam int unsigned MX = 950;
  localparam int unsigned TO = 1200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b1;
  logic [7:0] value;
  logic       valid, range_err, signal_lost;

  always #5 clk = ~clk;

  pwm_capture #(
    .OFFSET_CYCLES   (O),
    .TICK_CYCLES     (T),
    .MAX_HIGH_CYCLES (MX),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .value       (value),
    .valid       (valid),
    .range_err   (range_err),
    .signal_lost (signal_lost)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d", name, actual, expected);
    end
  endtask

  // One expected strobe: earliest edge it may appear on, and what it must carry.
  typedef struct {
    int unsigned due;
    logic        vld;
    logic        err;
    logic        good;
    logic [7:0]  val;
  } ev_t;

  ev_t exp_q[$];

  // Outcome of a pulse whose high level is first sampled on edge a and lasts w edges.
  function automatic ev_t predict(input int unsigned a, input int unsigned w);
    ev_t e;
    if (w >= MX) begin
      e.due = a + MX + 1; e.vld = 1'b0; e.err = 1'b1; e.good = 1'b0; e.val = 8'd0;
    end else if (w < O) begin
      e.due = a + w + 2; e.vld = 1'b1; e.err = 1'b1; e.good = 1'b0; e.val = 8'd0;
    end else begin
      e.due = a + w + 2; e.vld = 1'b1; e.err = 1'b0; e.good = 1'b1;
      e.val = ((w - O) / T > 255) ? 8'd255 : 8'((w - O) / T);
    end
    return e;
  endfunction

  int unsigned cyc = 0;
  int unsigned last_rise = 0;
  logic [3:0]  samp = '0;
  logic [7:0]  exp_value = 8'd0;
  logic        exp_lost = 1'b1;
  logic        rst_s, fire;
  ev_t         cur;

  // Compare process: model update on each rising edge, output check 1 time unit later.
  initial forever begin
    @(posedge clk);
    cyc++;
    rst_s = rst;
    fire  = 1'b0;
    if (!rst_s) begin
      samp = '0;
      last_rise = cyc;
      exp_q.delete();
      exp_value = 8'd0;
      exp_lost  = 1'b1;
    end else begin
      samp = {samp[2:0], pwm_in};
      fire = (cyc - last_rise == TO);
      if (samp[2] && !samp[3]) last_rise = cyc;
    end
    #1;
    if (!rst_s) begin
      check("reset_valid", valid, 0);
      check("reset_range_err", range_err, 0);
      check("reset_value", value, 0);
      check("reset_signal_lost", signal_lost, 1);
    end else begin
      if (valid || range_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {valid, range_err}, 0);
        end else begin
          cur = exp_q.pop_front();
          check("strobe_not_early", cyc >= cur.due, 1);
          check("strobe_not_late", cyc <= cur.due + 2, 1);
          check("strobe_valid", valid, cur.vld);
          check("strobe_range_err", range_err, cur.err);
          if (cur.vld)  exp_value = cur.val;
          if (cur.good) exp_lost  = 1'b0;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 2) begin
        cur = exp_q.pop_front();
        check("missed_strobe_edge", cyc, cur.due);
      end
      if (fire) exp_lost = 1'b1;
      check("value", value, exp_value);
      check("signal_lost", signal_lost, exp_lost);
    end
  end

  // Driver tasks run aligned to the falling edge.
  task automatic pulse(input int unsigned w, input bit expect_event);
    pwm_in = 1'b1;
    if (expect_event) exp_q.push_back(predict(cyc + 1, w));
    repeat (w) @(negedge clk);
    pwm_in = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    pwm_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int unsigned boundary [14] = '{99, 100, 101, 102, 103, 864, 866, 867, 868, 869, 948, 949, 950, 951};
  int unsigned w, kind;

  initial begin
    // Reset with the input already high: that partial pulse must never be measured.
    repeat (4) @(negedge clk);
    check("init_signal_lost", signal_lost, 1);
    check("init_value", value, 0);
    check("init_valid", valid, 0);
    rst = 1'b1;
    pulse(O + 128 * T, 1'b0);
    idle(50);
    check("wait_low_signal_lost", signal_lost, 1);

    pulse(484, 1'b1); idle(10);
    check("decode_128", value, 128);
    check("lost_cleared", signal_lost, 0);
    pulse(100, 1'b1); idle(10);
    check("decode_offset_zero", value, 0);
    pulse(868, 1'b1); idle(10);
    check("decode_saturated", value, 255);
    pulse(864, 1'b1); idle(10);
    check("decode_254", value, 254);
    pulse(60, 1'b1); idle(10);
    check("short_value_zero", value, 0);
    pulse(1000, 1'b1); idle(10);
    check("long_value_held", value, 0);

    // Reset in the middle of a measurement, released while the input is still high.
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_value", value, 0);
    check("midreset_signal_lost", signal_lost, 1);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    idle(20);
    pulse(484, 1'b1); idle(10);
    check("after_reset_decode", value, 128);

    // Loss of signal and recovery.
    idle(TO + 100);
    check("timeout_signal_lost", signal_lost, 1);
    check("timeout_value_held", value, 128);
    pulse(484, 1'b1); idle(10);
    check("recovered_signal_lost", signal_lost, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      w = $urandom_range(1, O - 1);
      else if (kind <= 2) w = boundary[$urandom_range(0, 13)];
      else if (kind == 3) w = $urandom_range(MX, MX + 150);
      else                w = $urandom_range(O, MX - 1);
      pulse(w, 1'b1);
      idle($urandom_range(5, 200));
    end

    idle(20);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
